// File: rtl/wshb_rst_pkg.sv
// -----------------------------------------------------------------------------
// wshb_rst_pkg
// Shared types and constants for the wshb PLL supervisor / reset sequencer.
//   state_t        : sequencer states (PLL_RST, WAIT_LOCK, STABLE, RUN)
//   DEF_*          : default values for the sequencer parameters
//   LOCK_LOSS_MAX  : saturation value of the lock-loss event counter
//   max3()         : elaboration-time helper used to size the sequencer counter
//   sat_inc8()     : saturating 8-bit increment for the lock-loss counter
// -----------------------------------------------------------------------------
package wshb_rst_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  localparam logic [7:0] LOCK_LOSS_MAX = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == LOCK_LOSS_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wshb_bit_sync.sv
// -----------------------------------------------------------------------------
// wshb_bit_sync
// Single-bit clock-domain-crossing synchroniser: a chain of SYNC_STAGES flops.
// Every flop resets asynchronously to 0. Generic; also used by other
// single-bit asynchronous paths.
// Parameters:
//   SYNC_STAGES : number of flops in the chain (>= 2)
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input bit
//   q      out  synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module wshb_bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/wshb_pll_rst_ctrl.sv
// -----------------------------------------------------------------------------
// wshb_pll_rst_ctrl
// PLL supervisor and reset sequencer. Pulses the PLL reset, waits for the
// synchronised lock, requires the lock to stay up for STABLE_CYCLES before
// releasing the system reset, and re-sequences the PLL on any loss of lock
// while running. Lock-loss events are counted (saturating at 255).
//
// Optional feature (compile-time macro WSHB_PLL_RST_LOCK_TIMEOUT_EN):
//   when defined, WAIT_LOCK gives up after TIMEOUT_CYCLES without lock,
//   re-pulses the PLL reset and counts the timeout as a lock-loss event.
//   When undefined, WAIT_LOCK waits indefinitely and TIMEOUT_CYCLES does not
//   influence the counter width.
//
// Parameters:
//   SYNC_STAGES    : depth of the pll_locked synchroniser (>= 2)
//   PLL_RST_CYCLES : cycles pll_rst stays high per pulse (>= 1)
//   STABLE_CYCLES  : consecutive locked cycles before release (>= 1)
//   TIMEOUT_CYCLES : lock-wait timeout, optional feature only (>= 1)
// Ports:
//   clk            in   50 MHz board reference clock (also PLL refclk)
//   reset_n        in   asynchronous active-low reset
//   pll_locked     in   PLL lock indicator, asynchronous to clk
//   pll_rst        out  active-high PLL reset
//   sys_rst_n      out  active-low system reset, synchronous to clk
//   ready          out  high while in RUN
//   lock_loss_cnt  out  saturating lock-loss event count
// -----------------------------------------------------------------------------
module wshb_pll_rst_ctrl
  import wshb_rst_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam bit PARAMS_OK = (SYNC_STAGES >= 2) && (PLL_RST_CYCLES >= 1) &&
                             (STABLE_CYCLES >= 1) && (TIMEOUT_CYCLES >= 1);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("wshb_pll_rst_ctrl: illegal parameter value");
    end
  endgenerate

  // The timeout only contributes to the counter width when it is used.
`ifdef WSHB_PLL_RST_LOCK_TIMEOUT_EN
  localparam int CNT_MAX = max3(PLL_RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
`else
  localparam int CNT_MAX = max3(PLL_RST_CYCLES, STABLE_CYCLES, 1);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
`ifdef WSHB_PLL_RST_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             locked_s;

  wshb_bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Outputs are plain flops updated together with the state, so they change
  // on exactly the edge that performs the transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= PLL_RST;
      cnt_reg       <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      case (state_reg)
        PLL_RST: begin
          // Lock is ignored while the PLL is held in reset.
          if (cnt_reg == PLL_RST_LAST) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
            pll_rst   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (locked_s) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end
`ifdef WSHB_PLL_RST_LOCK_TIMEOUT_EN
          else if (cnt_reg == TIMEOUT_LAST) begin
            state_reg     <= PLL_RST;
            cnt_reg       <= '0;
            pll_rst       <= 1'b1;
            lock_loss_cnt <= sat_inc8(lock_loss_cnt);
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
`endif
        end

        STABLE: begin
          // A drop on the completing cycle wins over entering RUN.
          if (!locked_s) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            state_reg     <= PLL_RST;
            cnt_reg       <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= sat_inc8(lock_loss_cnt);
          end
        end

        default: begin
          // Unreachable encoding: restart the sequence from a safe state.
          state_reg <= PLL_RST;
          cnt_reg   <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wshb_pll_rst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wshb_pll_rst_ctrl
// Self-checking bench for wshb_pll_rst_ctrl (SYNC_STAGES=2, PLL_RST_CYCLES=4,
// STABLE_CYCLES=8, TIMEOUT_CYCLES=20). Expected output words
// {pll_rst, sys_rst_n, ready, lock_loss_cnt} are pushed with the stimulus and
// compared when the targeted clock edge has produced its outputs.
// Honours WSHB_PLL_RST_LOCK_TIMEOUT_EN for the lock-wait scenario.
// -----------------------------------------------------------------------------
module tb_wshb_pll_rst_ctrl;

  localparam int SYNC = 2;
  localparam int PRC  = 4;
  localparam int STC  = 8;
  localparam int TOC  = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_llc = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [10:0] val;
  } exp_t;

  exp_t sb_q[$];

  wshb_pll_rst_ctrl #(
    .SYNC_STAGES    (SYNC),
    .PLL_RST_CYCLES (PRC),
    .STABLE_CYCLES  (STC),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] pk(input bit pr, input bit sr, input bit rd, input int llc);
    return {pr, sr, rd, 8'(llc)};
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compares every expectation whose target edge has passed.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        check_value(e.tag, {21'd0, pll_rst, sys_rst_n, ready, lock_loss_cnt}, e.val);
      end
    end
  end

  // Drive pll_locked for the next edge and expect v after that edge.
  task automatic drive(input bit lock, input logic [10:0] v, input string tag);
    exp_t e;
    pll_locked = lock;
    e.cyc = cyc + 1;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_llc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Asynchronous reset pulse, checked well before the next clock edge.
  task automatic do_reset(input bit lock_during, input string tag);
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    pll_locked = lock_during;
    #1;
    check_value(tag, {21'd0, pll_rst, sys_rst_n, ready, lock_loss_cnt}, {21'd0, pk(1, 0, 0, 0)});
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_llc = 0;
    $display("reset pulse %s: outputs pll_rst=%0b sys_rst_n=%0b cnt=%0d", tag, pll_rst, sys_rst_n, lock_loss_cnt);
  endtask

  // Lock held high from reset release: lock_s is seen in WAIT_LOCK at edge 5.
  task automatic bring_up(input int n_edges, input string tag);
    for (int e = 1; e <= n_edges; e++) begin
      if (e < PRC)
        drive(1'b1, pk(1, 0, 0, 0), tag);
      else if (e < PRC + 1 + STC)
        drive(1'b1, pk(0, 0, 0, 0), tag);
      else
        drive(1'b1, pk(0, 1, 1, 0), tag);
    end
    $display("bring_up %s: %0d edges sys_rst_n=%0b", tag, n_edges, sys_rst_n);
  endtask

  // From RUN: drop lock (seen two edges later), PLL reset pulse, relock.
  task automatic run_loss(input bit glitch, input int idx);
    for (int k = 1; k <= SYNC; k++) drive(1'b0, pk(0, 1, 1, exp_llc), "loss_run");
    exp_llc = sat_llc(exp_llc);
    for (int k = 1; k <= PRC; k++) drive(1'b0, pk(1, 0, 0, exp_llc), "loss_pll_rst");
    for (int k = 1; k <= 2; k++) drive(1'b0, pk(0, 0, 0, exp_llc), "loss_wait");
    if (glitch) begin
      // 7 edges high, 3 low, then high: the stable run restarts from zero.
      for (int j = 1; j <= 20; j++)
        drive((j <= 7 || j >= 11), pk(0, 0, 0, exp_llc), "glitch_hold");
      drive(1'b1, pk(0, 1, 1, exp_llc), "glitch_run");
    end else begin
      for (int j = 1; j <= SYNC + STC; j++) drive(1'b1, pk(0, 0, 0, exp_llc), "relock_hold");
      drive(1'b1, pk(0, 1, 1, exp_llc), "relock_run");
    end
    $display("loss %0d glitch=%0b: lock_loss_cnt=%0d ready=%0b", idx, glitch, lock_loss_cnt, ready);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_state", {21'd0, pll_rst, sys_rst_n, ready, lock_loss_cnt}, {21'd0, pk(1, 0, 0, 0)});
    reset_n = 1'b1;

    // Lock held low after reset release.
    for (int e = 1; e <= 60; e++) begin
`ifdef WSHB_PLL_RST_LOCK_TIMEOUT_EN
      drive(1'b0, pk((e % (PRC + TOC)) < PRC, 0, 0, e / (PRC + TOC)), "s1_timeout");
`else
      drive(1'b0, pk(e < PRC, 0, 0, 0), "s1_pll_rst");
`endif
    end
`ifdef WSHB_PLL_RST_LOCK_TIMEOUT_EN
    exp_llc = 60 / (PRC + TOC);
`else
    exp_llc = 0;
`endif
    $display("s1 no lock: pll_rst=%0b sys_rst_n=%0b lock_loss_cnt=%0d", pll_rst, sys_rst_n, lock_loss_cnt);

    // First lock: RUN exactly SYNC+STC+1 edges after lock is first sampled.
    for (int k = 1; k <= SYNC + STC + 1; k++)
      drive(1'b1, (k == SYNC + STC + 1) ? pk(0, 1, 1, exp_llc) : pk(0, 0, 0, exp_llc), "s2_lock");
    repeat (3) drive(1'b1, pk(0, 1, 1, exp_llc), "s2_run");
    $display("s2 lock: sys_rst_n=%0b ready=%0b", sys_rst_n, ready);

    // Loss with an interrupted stable interval, then 300 plain losses.
    run_loss(1'b1, 0);
    for (int i = 1; i <= 300; i++) run_loss(1'b0, i);
    check_value("s4_saturate", {24'd0, lock_loss_cnt}, 32'd255);

    // Reset mid-RUN, then mid-STABLE.
    do_reset(1'b1, "rst_mid_run");
    bring_up(PRC + 1 + STC, "after_rst_run");
    do_reset(1'b1, "rst_mid_stable_pre");
    bring_up(7, "to_stable");
    do_reset(1'b1, "rst_mid_stable");
    bring_up(PRC + 1 + STC + 2, "after_rst_stable");

    @(negedge clk);
    #2;
    check_value("sb_drain", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
